// File: rtl/inst_fetch_pkg.sv
// Shared fetch/decode definitions: opcodes, NOP encoding, buffer entry type and
// immediate extraction helpers used by static prediction.
package inst_fetch_pkg;

    localparam logic [6:0]  OPCODE_JAL    = 7'b110_1111;
    localparam logic [6:0]  OPCODE_BRANCH = 7'b110_0011;
    localparam logic [31:0] NOP           = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fe_entry_t;

    function automatic logic [31:0] jal_imm(input logic [31:0] ir);
        return {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] b_imm(input logic [31:0] ir);
        return {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Small instruction buffer holding {pc, ir} entries between memory and decode.
// Flush wins over push/pop; push and pop together are legal at any fill level.
module fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = $bits(fe_entry_t)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           rdata_o,
    output logic                       empty_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push_i, pop_i})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: cnt_q gates every read of it.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues word fetches, buffers responses, hands one
// instruction per cycle to decode and applies static prediction and redirects.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        de_stall_i,
    input  logic        branch_predict_err_i,
    input  logic [31:0] de2fe_branch_target_i,
    input  logic        ex2fe_redirect_i,
    input  logic [31:0] ex2fe_redirect_pc_i,
    output logic [31:0] fe2de_pc_ffout_o,
    output logic [31:0] fe2de_ir_ffout_o,
    output logic        fe2de_predict_bxxtaken_ffout_o,
    output logic        fe2de_rv16_ffout_o,
    output logic        fe2de_valid_ffout_o
);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     resp_pc_q, resp_pc_d;
    logic [CntW-1:0] out_cnt_q, out_cnt_d;
    logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic            pred_q, pred_d;
    logic            valid_q, valid_d;

    logic            fifo_push, fifo_pop, fifo_empty;
    logic [CntW-1:0] fifo_count;
    fe_entry_t       fifo_head, fifo_wdata;

    logic            ex_redir, bp_redir, pred_redir, redirect, handoff;
    logic            is_jal, is_bneg;
    logic [31:0]     target;
    logic [CntW:0]   occupancy;

    fetch_fifo #(
        .Depth (FIFO_DEPTH),
        .Width ($bits(fe_entry_t))
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (redirect),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Redirect arbitration: execute > decode mispredict > fetch-side prediction.
    always_comb begin
        ex_redir   = ex2fe_redirect_i;
        bp_redir   = branch_predict_err_i && !de_stall_i && !ex_redir;
        handoff    = !de_stall_i && !ex_redir && !bp_redir;
        fifo_pop   = handoff && !fifo_empty;
        is_jal     = (fifo_head.ir[6:0] == OPCODE_JAL);
        is_bneg    = (fifo_head.ir[6:0] == OPCODE_BRANCH) && fifo_head.ir[31];
        pred_redir = fifo_pop && (is_jal || is_bneg);
        redirect   = ex_redir || bp_redir || pred_redir;
        if (ex_redir) begin
            target = ex2fe_redirect_pc_i;
        end else if (bp_redir) begin
            target = de2fe_branch_target_i;
        end else if (is_jal) begin
            target = fifo_head.pc + jal_imm(fifo_head.ir);
        end else begin
            target = fifo_head.pc + b_imm(fifo_head.ir);
        end
        target = target & ~32'h3;
    end

    // A word being popped this cycle frees its slot for a new request.
    always_comb begin
        occupancy   = {1'b0, out_cnt_q} + {1'b0, fifo_count} - {{CntW{1'b0}}, fifo_pop};
        // Gating with reset keeps the bus idle while held in reset.
        imem_req_o  = rst_ni && !redirect && (occupancy < (CntW + 1)'(FIFO_DEPTH));
        imem_addr_o = imem_req_o ? fetch_pc_q : '0;
        fifo_push   = imem_rvalid_i && (drop_cnt_q == '0) && !redirect;
        fifo_wdata  = '{pc: resp_pc_q, ir: imem_rdata_i};
    end

    always_comb begin
        case ({imem_req_o, imem_rvalid_i})
            2'b10:   out_cnt_d = out_cnt_q + 1'b1;
            2'b01:   out_cnt_d = out_cnt_q - 1'b1;
            default: out_cnt_d = out_cnt_q;
        endcase

        drop_cnt_d = drop_cnt_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        if (redirect) begin
            // Everything still in flight after this cycle belongs to the old path.
            drop_cnt_d = out_cnt_d;
            fetch_pc_d = target;
            resp_pc_d  = target;
        end else begin
            if (imem_rvalid_i && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
            if (imem_req_o) fetch_pc_d = fetch_pc_q + 32'd4;
            if (fifo_push)  resp_pc_d  = resp_pc_q + 32'd4;
        end
    end

    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        pred_d  = pred_q;
        valid_d = valid_q;
        if (ex_redir || bp_redir || (handoff && fifo_empty)) begin
            ir_d    = NOP;
            pred_d  = 1'b0;
            valid_d = 1'b0;
        end else if (fifo_pop) begin
            pc_d    = fifo_head.pc;
            ir_d    = fifo_head.ir;
            pred_d  = is_bneg;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            pc_q       <= RESET_PC;
            ir_q       <= NOP;
            pred_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            pred_q     <= pred_d;
            valid_q    <= valid_d;
        end
    end

    assign fe2de_pc_ffout_o               = pc_q;
    assign fe2de_ir_ffout_o               = ir_q;
    assign fe2de_predict_bxxtaken_ffout_o = pred_q;
    assign fe2de_rv16_ffout_o             = 1'b0;
    assign fe2de_valid_ffout_o            = valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: in-order memory model with adjustable latency and a
// program-order scoreboard of expected decode-stage instructions.
module tb_inst_fetch;

    localparam logic [31:0] NOP_W = 32'h0000_0013;
    localparam logic [31:0] BEQ_W = 32'hFE00_0CE3;  // beq x0,x0,-8
    localparam logic [31:0] JAL_W = 32'h1000_00EF;  // jal ra,+0x100

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic        pred;
        logic        valid;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mreq_t;

    logic        clk, rst_n;
    logic        imem_req, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        de_stall, bp_err, ex_redir;
    logic [31:0] bp_target, ex_pc;
    logic [31:0] fe_pc, fe_ir;
    logic        fe_pred, fe_rv16, fe_valid;

    int n_vec = 0;
    int n_err = 0;
    int inflight = 0;
    int retired = 0;
    logic [31:0] last_pc = 32'hFFFF_FFFF;
    bit loaded, mon_on, beq_retired, beq_served;
    int unsigned mem_lat = 1;
    int unsigned cyc;
    mreq_t mq[$];
    exp_t exp_q[$];
    exp_t cur;

    inst_fetch #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk_i                          (clk),
        .rst_ni                         (rst_n),
        .imem_req_o                     (imem_req),
        .imem_addr_o                    (imem_addr),
        .imem_rvalid_i                  (imem_rvalid),
        .imem_rdata_i                   (imem_rdata),
        .de_stall_i                     (de_stall),
        .branch_predict_err_i           (bp_err),
        .de2fe_branch_target_i          (bp_target),
        .ex2fe_redirect_i               (ex_redir),
        .ex2fe_redirect_pc_i            (ex_pc),
        .fe2de_pc_ffout_o               (fe_pc),
        .fe2de_ir_ffout_o               (fe_ir),
        .fe2de_predict_bxxtaken_ffout_o (fe_pred),
        .fe2de_rv16_ffout_o             (fe_rv16),
        .fe2de_valid_ffout_o            (fe_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] addi_w(input logic [31:0] a);
        return {a[11:0], 5'd0, 3'b000, 5'd1, 7'h13};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a, input bit beq_gone);
        if (a == 32'h10 && !beq_gone) return BEQ_W;
        if (a == 32'h20) return JAL_W;
        return addi_w(a);
    endfunction

    function automatic exp_t mk(input logic [31:0] pc, input bit beq_gone);
        logic [31:0] w;
        w = mem_word(pc, beq_gone);
        return '{pc: pc, ir: w, pred: (w == BEQ_W), valid: 1'b1};
    endfunction

    function automatic logic [31:0] next_pc(input exp_t e);
        if (e.ir == BEQ_W) return e.pc - 32'd8;
        if (e.ir == JAL_W) return e.pc + 32'h100;
        return e.pc + 32'd4;
    endfunction

    // Instruction memory: accepts every request, answers in order after mem_lat cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
            cyc         <= 0;
            beq_served  <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (imem_req) mq.push_back('{imem_addr, cyc + mem_lat - 1});
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= mem_word(mq[0].addr, beq_served);
                if (mq[0].addr == 32'h10) beq_served <= 1'b1;
                void'(mq.pop_front());
            end else begin
                imem_rvalid <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        exp_q.delete();
        exp_q.push_back(mk(pc, beq_retired));
    endtask

    task automatic monitor();
        exp_t e;
        if (!loaded) begin
            chk("hold_pc", fe_pc, cur.pc);
            chk("hold_ir", fe_ir, cur.ir);
            chk("hold_valid", fe_valid, cur.valid);
        end else if (fe_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_pc", fe_pc, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", fe_pc, e.pc);
                chk("sb_ir", fe_ir, e.ir);
                chk("sb_pred", fe_pred, e.pred);
                cur = e;
                last_pc = fe_pc;
                retired++;
                if (e.ir == BEQ_W) beq_retired = 1'b1;
                exp_q.push_back(mk(next_pc(e), beq_retired));
            end
        end else begin
            chk("bubble_ir", fe_ir, NOP_W);
            chk("bubble_pred", fe_pred, 1'b0);
            chk("bubble_pc", fe_pc, cur.pc);
            cur = '{pc: cur.pc, ir: NOP_W, pred: 1'b0, valid: 1'b0};
        end
    endtask

    task automatic tick();
        @(posedge clk);
        loaded = !de_stall || ex_redir;
        if (imem_req && !imem_rvalid) inflight++;
        else if (!imem_req && imem_rvalid) inflight--;
        @(negedge clk);
        chk("inflight_cap", (inflight <= 2), 1'b1);
        if (imem_req) chk("addr_align", imem_addr[1:0], 2'b00);
        if (mon_on) monitor();
    endtask

    initial begin
        rst_n = 1'b0;
        de_stall = 1'b0;
        bp_err = 1'b0;
        bp_target = '0;
        ex_redir = 1'b0;
        ex_pc = '0;
        mon_on = 1'b0;
        beq_retired = 1'b0;
        cur = '{pc: 32'h0, ir: NOP_W, pred: 1'b0, valid: 1'b0};
        repeat (3) @(negedge clk);

        chk("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pc", fe_pc, 32'h0);
        chk("rst_ir", fe_ir, NOP_W);
        chk("rst_valid", fe_valid, 1'b0);
        chk("rst_pred", fe_pred, 1'b0);
        chk("rst_rv16", fe_rv16, 1'b0);

        // Straight-line start-up with 1-cycle memory.
        rst_n = 1'b1;
        #1;
        chk("req0", imem_req, 1'b1);
        chk("addr0", imem_addr, 32'h0);
        exp_q.push_back(mk(32'h0, 1'b0));
        mon_on = 1'b1;
        tick();
        chk("req1", imem_req, 1'b1);
        chk("addr1", imem_addr, 32'h4);
        tick();
        chk("req2", imem_req, 1'b1);
        chk("addr2", imem_addr, 32'h8);
        tick();
        chk("c3_valid", fe_valid, 1'b1);
        chk("c3_pc", fe_pc, 32'h0);
        tick();
        chk("c4_pc", fe_pc, 32'h4);
        tick();
        chk("c5_pc", fe_pc, 32'h8);

        // BEQ at 0x10 loops back to 0x08, then JAL at 0x20 jumps to 0x120.
        for (int i = 0; i < 150 && last_pc != 32'h124; i++) tick();
        chk("reach_jal_path", last_pc, 32'h124);

        // Mispredict pulse while stalled must be ignored.
        de_stall = 1'b1;
        tick();
        tick();
        bp_err = 1'b1;
        bp_target = 32'h44;
        tick();
        bp_err = 1'b0;
        tick();
        de_stall = 1'b0;
        repeat (6) tick();

        // Mispredict while not stalled: bubble, then 0x44 four cycles later.
        bp_err = 1'b1;
        bp_target = 32'h44;
        redirect_to(32'h44);
        tick();
        bp_err = 1'b0;
        chk("bperr_bubble_valid", fe_valid, 1'b0);
        chk("bperr_bubble_ir", fe_ir, NOP_W);
        repeat (3) tick();
        chk("bperr_tgt_valid", fe_valid, 1'b1);
        chk("bperr_tgt_pc", fe_pc, 32'h44);

        // Execute redirect with two words in flight on a 3-cycle memory, while stalled.
        mem_lat = 3;
        repeat (12) tick();
        for (int i = 0; i < 20 && inflight != 2; i++) tick();
        chk("ex_inflight_two", inflight, 2);
        ex_redir = 1'b1;
        ex_pc = 32'h203;
        de_stall = 1'b1;
        redirect_to(32'h200);
        tick();
        ex_redir = 1'b0;
        chk("ex_bubble_valid", fe_valid, 1'b0);
        chk("ex_bubble_ir", fe_ir, NOP_W);
        repeat (4) tick();
        de_stall = 1'b0;
        begin
            int r0;
            r0 = retired;
            for (int i = 0; i < 20 && retired == r0; i++) tick();
            chk("ex_first_pc", last_pc, 32'h200);
        end

        // Random decode stalls on the slow memory: order and capacity must hold.
        begin
            int r0;
            r0 = retired;
            for (int i = 0; i < 200; i++) begin
                de_stall = 1'($urandom_range(0, 1));
                tick();
            end
            de_stall = 1'b0;
            repeat (8) tick();
            chk("stall_progress", (retired - r0 >= 40), 1'b1);
        end
        chk("end_rv16", fe_rv16, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
